// File: rtl/ram_arbiter_rr_if.sv
// Bundles the per-core cache ports and the shared RAM port of ram_arbiter_rr.
// The arbiter uses the slave view; the caches/RAM environment use the master view.
interface ram_arbiter_rr_if #(
  parameter int CPUS   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [CPUS-1:0]        iREN;
  logic [CPUS*ADDR_W-1:0] iaddr;
  logic [CPUS-1:0]        iwait;
  logic [CPUS*DATA_W-1:0] iload;
  logic [CPUS-1:0]        dREN;
  logic [CPUS-1:0]        dWEN;
  logic [CPUS*ADDR_W-1:0] daddr;
  logic [CPUS*DATA_W-1:0] dstore;
  logic [CPUS-1:0]        dwait;
  logic [CPUS*DATA_W-1:0] dload;
  logic                   ramREN;
  logic                   ramWEN;
  logic [ADDR_W-1:0]      ramaddr;
  logic [DATA_W-1:0]      ramstore;
  logic [DATA_W-1:0]      ramload;
  logic [1:0]             ramstate;
  logic                   timeout_err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, timeout_err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, timeout_err
  );
endinterface

// File: rtl/ram_arbiter_rr.sv
// Registered-grant RAM arbiter: dcache over icache, round-robin within each class.
// Define ARB_TIMEOUT_EN to abort transactions on RAM ERROR or after TIMEOUT ACTIVE cycles.
module ram_arbiter_rr #(
  parameter int CPUS    = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  ram_arbiter_rr_if.slave   bus
);
  localparam int IDX_W = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [1:0] RAM_ACCESS = 2'b10;
  localparam logic [1:0] RAM_ERROR  = 2'b11;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state, state_next;
  logic             grant_d, grant_d_next;
  logic [IDX_W-1:0] grant_idx, grant_idx_next;
  logic [IDX_W-1:0] d_ptr, d_ptr_next, i_ptr, i_ptr_next;
  logic [CPUS-1:0]  dreq, ireq;
  logic             d_found, i_found;
  logic [IDX_W-1:0] d_pick, i_pick;
  logic             granted_req, access, abort;

  // Scan downward so the requester closest at/after ptr is the last to overwrite the result.
  function automatic logic [IDX_W:0] pick_rr(input logic [CPUS-1:0] req,
                                             input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0] res;
    int j;
    res = '0;
    for (int i = CPUS - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % CPUS;
      if (req[j]) res = {1'b1, IDX_W'(j)};
    end
    return res;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return IDX_W'((int'(idx) + 1) % CPUS);
  endfunction

  assign dreq        = bus.dREN | bus.dWEN;
  assign ireq        = bus.iREN;
  assign granted_req = grant_d ? dreq[grant_idx] : ireq[grant_idx];
  assign access      = (state == ACTIVE) && granted_req && (bus.ramstate == RAM_ACCESS);
  assign bus.iload   = {CPUS{bus.ramload}};
  assign bus.dload   = {CPUS{bus.ramload}};

  always_comb begin
    {d_found, d_pick} = pick_rr(dreq, d_ptr);
    {i_found, i_pick} = pick_rr(ireq, i_ptr);
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] tcount;

  assign abort = (state == ACTIVE) && granted_req && !access &&
                 ((bus.ramstate == RAM_ERROR) || (int'(tcount) == TIMEOUT - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                                     tcount <= '0;
    else if (state == IDLE && state_next == ACTIVE) tcount <= '0;
    else if (state == ACTIVE)                      tcount <= tcount + 8'd1;
  end
`else
  assign abort = 1'b0;
`endif

  assign bus.timeout_err = abort;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      grant_d   <= 1'b0;
      grant_idx <= '0;
      d_ptr     <= '0;
      i_ptr     <= '0;
    end else begin
      state     <= state_next;
      grant_d   <= grant_d_next;
      grant_idx <= grant_idx_next;
      d_ptr     <= d_ptr_next;
      i_ptr     <= i_ptr_next;
    end
  end

  // A dropped request ends the transaction without moving the pointer; completion or abort moves it.
  always_comb begin
    state_next     = state;
    grant_d_next   = grant_d;
    grant_idx_next = grant_idx;
    d_ptr_next     = d_ptr;
    i_ptr_next     = i_ptr;
    case (state)
      IDLE: begin
        if (d_found) begin
          grant_d_next   = 1'b1;
          grant_idx_next = d_pick;
          state_next     = ACTIVE;
        end else if (i_found) begin
          grant_d_next   = 1'b0;
          grant_idx_next = i_pick;
          state_next     = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!granted_req) begin
          state_next = IDLE;
        end else if (access || abort) begin
          state_next = IDLE;
          if (grant_d) d_ptr_next = next_idx(grant_idx);
          else         i_ptr_next = next_idx(grant_idx);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    if (state == ACTIVE) begin
      if (grant_d) begin
        bus.ramWEN   = bus.dWEN[grant_idx];
        bus.ramREN   = bus.dREN[grant_idx] & ~bus.dWEN[grant_idx];
        bus.ramaddr  = bus.daddr[int'(grant_idx)*ADDR_W +: ADDR_W];
        bus.ramstore = bus.dstore[int'(grant_idx)*DATA_W +: DATA_W];
      end else begin
        bus.ramREN   = bus.iREN[grant_idx];
        bus.ramaddr  = bus.iaddr[int'(grant_idx)*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    bus.iwait = ireq;
    bus.dwait = dreq;
    if (access) begin
      if (grant_d) bus.dwait[grant_idx] = 1'b0;
      else         bus.iwait[grant_idx] = 1'b0;
    end
  end
endmodule

// File: tb/tb_ram_arbiter_rr.sv
// Self-checking bench for ram_arbiter_rr (CPUS=2): a RAM responder model plus a grant-order scoreboard.
// Timeout expectations switch on ARB_TIMEOUT_EN.
module tb_ram_arbiter_rr;
  localparam int CPUS = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;

  typedef struct {
    logic        d;
    int          idx;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic CLK = 1'b0;
  logic nRST;
  int   checks = 0;
  int   errors = 0;
  int   accessLat = 1;
  int   busyCnt = 0;
  exp_t sbq[$];
  exp_t monEntry;
  logic monWait;

  ram_arbiter_rr_if #(.CPUS(CPUS), .ADDR_W(AW), .DATA_W(DW)) bus();

  ram_arbiter_rr #(.CPUS(CPUS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // RAM model: ACCESS once enables have been high for accessLat consecutive cycles.
  always begin
    @(posedge CLK);
    #2;
    if (bus.ramREN || bus.ramWEN) begin
      busyCnt++;
      bus.ramstate = (busyCnt >= accessLat) ? 2'b10 : 2'b01;
    end else begin
      busyCnt = 0;
      bus.ramstate = 2'b00;
    end
  end

  // Scoreboard: every ACCESS cycle must match the next expected grant.
  always @(negedge CLK) begin
    if (nRST && bus.ramstate == 2'b10 && (bus.ramREN || bus.ramWEN)) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_unexpected: access addr=%h with no expected grant", bus.ramaddr);
      end else begin
        monEntry = sbq.pop_front();
        monWait  = monEntry.d ? bus.dwait[monEntry.idx] : bus.iwait[monEntry.idx];
        if (bus.ramaddr !== monEntry.addr || bus.ramWEN !== monEntry.we ||
            bus.ramREN !== !monEntry.we || bus.ramstore !== monEntry.data || monWait !== 1'b0) begin
          errors++;
          $display("[TB] FAIL sb_access: got addr=%h wen=%b ren=%b store=%h wait=%b, expected addr=%h wen=%b ren=%b store=%h wait=0 (d=%b idx=%0d)",
                   bus.ramaddr, bus.ramWEN, bus.ramREN, bus.ramstore, monWait,
                   monEntry.addr, monEntry.we, !monEntry.we, monEntry.data, monEntry.d, monEntry.idx);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    bus.iREN = 2'b10; bus.dREN = '0; bus.dWEN = '0;
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
    bus.ramload = 32'hCAFE0001; bus.ramstate = 2'b00;
    #3;
    checks++;
    if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || bus.ramaddr !== '0 ||
        bus.ramstore !== '0 || bus.timeout_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: ren=%b wen=%b addr=%h store=%h terr=%b, expected all 0",
               bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.timeout_err);
    end
    checks++;
    if (bus.iwait !== 2'b10 || bus.dwait !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_waits: iwait=%b dwait=%b, expected 10 00", bus.iwait, bus.dwait);
    end
    checks++;
    if (bus.iload !== {2{32'hCAFE0001}} || bus.dload !== {2{32'hCAFE0001}}) begin
      errors++;
      $display("[TB] FAIL load_broadcast: iload=%h dload=%h, expected ramload on both cores", bus.iload, bus.dload);
    end
    nextCycle();
    bus.iREN = '0;
    nRST = 1'b1;

    // Mid-ACTIVE reset
    nextCycle();
    accessLat = 1000;
    bus.dREN = 2'b01;
    bus.daddr = {32'h0000_0014, 32'h0000_0010};
    nextCycle();
    @(negedge CLK);
    checks++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h10) begin
      errors++;
      $display("[TB] FAIL active_before_reset: ren=%b addr=%h, expected 1 00000010", bus.ramREN, bus.ramaddr);
    end
    #1 nRST = 1'b0;
    #1;
    checks++;
    if (bus.ramREN !== 1'b0 || bus.ramaddr !== '0 || bus.dwait[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_reset: ren=%b addr=%h dwait0=%b, expected 0 0 1", bus.ramREN, bus.ramaddr, bus.dwait[0]);
    end
    nextCycle();
    bus.dREN = '0;
    nextCycle();
    nRST = 1'b1;
    nextCycle();
  endtask

  task automatic test_priority();
    nextCycle();
    accessLat = 2;
    bus.iaddr = {32'h0000_1004, 32'h0000_1000};
    bus.daddr = {32'h0000_2004, 32'h0000_2000};
    bus.dstore = {32'hAAAA_0001, 32'hAAAA_0000};
    bus.iREN = 2'b01; bus.dREN = 2'b10;
    sbq.push_back('{1'b1, 1, 1'b0, 32'h0000_2004, 32'hAAAA_0001});
    sbq.push_back('{1'b0, 0, 1'b0, 32'h0000_1000, 32'h0});
    @(negedge CLK);
    checks++;
    if (bus.ramREN !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prio_idle: ren=%b, expected 0", bus.ramREN);
    end
    nextCycle();
    @(negedge CLK);
    checks++;
    if (bus.ramaddr !== 32'h0000_2004 || bus.iwait[0] !== 1'b1 || bus.dwait[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL prio_dgrant: addr=%h iwait0=%b dwait1=%b, expected 00002004 1 1",
               bus.ramaddr, bus.iwait[0], bus.dwait[1]);
    end
    nextCycle();
    @(negedge CLK);
    checks++;
    if (bus.iwait[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL prio_ihold: iwait0=%b, expected 1", bus.iwait[0]);
    end
    nextCycle();
    bus.dREN = '0;
    @(negedge CLK);
    checks++;
    if (bus.ramREN !== 1'b0 || bus.iwait[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL prio_gap: ren=%b iwait0=%b, expected 0 1", bus.ramREN, bus.iwait[0]);
    end
    nextCycle();
    @(negedge CLK);
    checks++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h0000_1000 || bus.iwait[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL prio_igrant: ren=%b addr=%h iwait0=%b, expected 1 00001000 1",
               bus.ramREN, bus.ramaddr, bus.iwait[0]);
    end
    nextCycle();
    nextCycle();
    bus.iREN = '0;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL prio_drain: %0d grants outstanding, expected 0", sbq.size());
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    nextCycle();
    accessLat = 2;
    bus.daddr = {32'h0000_0204, 32'h0000_0200};
    bus.dstore = {32'h2222_2222, 32'h1111_1111};
    bus.dWEN = 2'b11;
    for (int k = 0; k < 4; k++)
      sbq.push_back('{1'b1, k % 2, 1'b1, (k % 2) ? 32'h0000_0204 : 32'h0000_0200,
                      (k % 2) ? 32'h2222_2222 : 32'h1111_1111});
    cyc = 0;
    while (sbq.size() != 0 && cyc < 40) begin
      nextCycle();
      cyc++;
    end
    bus.dWEN = '0;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL rr_write_drain: %0d grants outstanding after %0d cycles, expected 0", sbq.size(), cyc);
    end
    sbq.delete();
    nextCycle();
  endtask

  task automatic test_drop();
    nextCycle();
    accessLat = 1000;
    bus.daddr = {32'h0000_0304, 32'h0000_0300};
    bus.dstore = {32'h3333_0001, 32'h3333_0000};
    bus.dREN = 2'b01;
    nextCycle();
    @(negedge CLK);
    checks++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h0000_0300) begin
      errors++;
      $display("[TB] FAIL drop_grant: ren=%b addr=%h, expected 1 00000300", bus.ramREN, bus.ramaddr);
    end
    nextCycle();
    bus.dREN = '0;
    @(negedge CLK);
    checks++;
    if (bus.ramREN !== 1'b0 || bus.dwait[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drop_release: ren=%b dwait0=%b, expected 0 0", bus.ramREN, bus.dwait[0]);
    end
    nextCycle();
    accessLat = 1;
    bus.dREN = 2'b11;
    sbq.push_back('{1'b1, 0, 1'b0, 32'h0000_0300, 32'h3333_0000});
    sbq.push_back('{1'b1, 1, 1'b0, 32'h0000_0304, 32'h3333_0001});
    @(negedge CLK);
    checks++;
    if (bus.ramREN !== 1'b0 || bus.dwait !== 2'b11) begin
      errors++;
      $display("[TB] FAIL drop_idle: ren=%b dwait=%b, expected 0 11", bus.ramREN, bus.dwait);
    end
    nextCycle();
    nextCycle();
    bus.dREN = 2'b10;
    nextCycle();
    nextCycle();
    bus.dREN = '0;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL drop_ptr_drain: %0d grants outstanding, expected 0", sbq.size());
    end
    sbq.delete();
  endtask

  task automatic test_write_priority();
    nextCycle();
    accessLat = 1;
    bus.daddr = {32'h0000_0000, 32'h0000_0100};
    bus.dstore = {32'h0, 32'hDEAD_BEEF};
    bus.dREN = 2'b01; bus.dWEN = 2'b01;
    sbq.push_back('{1'b1, 0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF});
    nextCycle();
    @(negedge CLK);
    checks++;
    if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0 || bus.ramaddr !== 32'h100 || bus.ramstore !== 32'hDEAD_BEEF) begin
      errors++;
      $display("[TB] FAIL write_wins: wen=%b ren=%b addr=%h store=%h, expected 1 0 00000100 deadbeef",
               bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore);
    end
    nextCycle();
    bus.dREN = '0; bus.dWEN = '0;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL write_drain: %0d grants outstanding, expected 0", sbq.size());
    end
    sbq.delete();
  endtask

  task automatic test_icache_rr();
    int cyc;
    nextCycle();
    accessLat = 1;
    bus.iaddr = {32'h0000_0404, 32'h0000_0400};
    bus.dstore = {32'h5555_5555, 32'h4444_4444};
    bus.iREN = 2'b11;
    sbq.push_back('{1'b0, 1, 1'b0, 32'h0000_0404, 32'h0});
    sbq.push_back('{1'b0, 0, 1'b0, 32'h0000_0400, 32'h0});
    cyc = 0;
    while (sbq.size() != 0 && cyc < 20) begin
      nextCycle();
      cyc++;
    end
    bus.iREN = '0;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL icache_rr_drain: %0d grants outstanding after %0d cycles, expected 0", sbq.size(), cyc);
    end
    sbq.delete();
    nextCycle();
  endtask

  task automatic test_timeout();
    nextCycle();
    accessLat = 1000;
    bus.iaddr = {32'h0000_0500, 32'h0};
    bus.iREN = 2'b10;
    for (int c = 1; c <= 3; c++) begin
      nextCycle();
      @(negedge CLK);
      checks++;
      if (bus.timeout_err !== 1'b0 || bus.ramREN !== 1'b1) begin
        errors++;
        $display("[TB] FAIL timeout_early: active cycle %0d terr=%b ren=%b, expected 0 1", c, bus.timeout_err, bus.ramREN);
      end
    end
    nextCycle();
    @(negedge CLK);
    checks++;
`ifdef ARB_TIMEOUT_EN
    if (bus.timeout_err !== 1'b1 || bus.iwait[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_pulse: terr=%b iwait1=%b, expected 1 1", bus.timeout_err, bus.iwait[1]);
    end
`else
    if (bus.timeout_err !== 1'b0 || bus.ramREN !== 1'b1) begin
      errors++;
      $display("[TB] FAIL no_timeout: terr=%b ren=%b, expected 0 1", bus.timeout_err, bus.ramREN);
    end
`endif
    nextCycle();
    @(negedge CLK);
    checks++;
`ifdef ARB_TIMEOUT_EN
    if (bus.ramREN !== 1'b0 || bus.timeout_err !== 1'b0 || bus.iwait[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_idle: ren=%b terr=%b iwait1=%b, expected 0 0 1", bus.ramREN, bus.timeout_err, bus.iwait[1]);
    end
`else
    if (bus.ramREN !== 1'b1 || bus.timeout_err !== 1'b0 || bus.iwait[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL still_active: ren=%b terr=%b iwait1=%b, expected 1 0 1", bus.ramREN, bus.timeout_err, bus.iwait[1]);
    end
`endif
    nextCycle();
    bus.iREN = '0;
    nextCycle();
    @(negedge CLK);
    checks++;
    if (bus.ramREN !== 1'b0 || bus.iwait !== 2'b00) begin
      errors++;
      $display("[TB] FAIL timeout_cleanup: ren=%b iwait=%b, expected 0 00", bus.ramREN, bus.iwait);
    end
  endtask

  initial begin
    $display("[TB] starting ram_arbiter_rr bench");
    test_reset();
    test_priority();
    test_back_to_back();
    test_drop();
    test_write_priority();
    test_icache_rr();
    test_timeout();
    repeat (3) nextCycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
